// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Instruction-cycle controller for the toy processor. It steps one 16-bit
// instruction (3-bit opcode, 13-bit address) through FETCH_HI, FETCH_LO,
// DECODE, EXEC1 and EXEC2, and parks in HALTED on HLT. It drives the PC
// increment/load strobes, IR byte loads, accumulator load, memory rd/wr,
// the address-source select and the data-bus enable.
//
// Optional feature macro: CPU_SEQ_MEMWAIT_EN
//   defined   : i_mem_rdy stalls the memory-facing states.
//   undefined : i_mem_rdy is ignored (treated as 1), so every state is one cycle.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_ena         run enable (low: state frozen, all strobes 0)
//   i_opcode[2:0] ir[15:13], valid from DECODE onward
//   i_zero        accumulator-is-zero flag, sampled in DECODE
//   i_mem_rdy     memory completes the current rd/wr this cycle
//   o_pc_inc      PC increment enable
//   o_pc_load     PC loads ir[12:0]
//   o_addr_sel    memory address source: 0 = PC, 1 = ir[12:0]
//   o_load_ir_hi  IR high byte captures memory data
//   o_load_ir_lo  IR low byte captures memory data
//   o_load_acc    accumulator captures ALU result
//   o_rd          memory read
//   o_wr          memory write
//   o_datactl_ena drive accumulator onto the data bus
//   o_halt        processor halted
// -----------------------------------------------------------------------------
module cpu_sequencer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ena,
    input  logic [2:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_rdy,
    output logic       o_pc_inc,
    output logic       o_pc_load,
    output logic       o_addr_sel,
    output logic       o_load_ir_hi,
    output logic       o_load_ir_lo,
    output logic       o_load_acc,
    output logic       o_rd,
    output logic       o_wr,
    output logic       o_datactl_ena,
    output logic       o_halt
);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH_HI = 3'd0,
        S_FETCH_LO = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC1    = 3'd3,
        S_EXEC2    = 3'd4,
        S_HALTED   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_zero_q;
    logic   w_mem_rdy;
    logic   w_run;

    logic w_pc_inc, w_pc_load, w_addr_sel, w_load_ir_hi, w_load_ir_lo;
    logic w_load_acc, w_rd, w_wr, w_datactl_ena, w_halt;

`ifdef CPU_SEQ_MEMWAIT_EN
    assign w_mem_rdy = i_mem_rdy;
`else
    // Port kept for pin compatibility; the OR forces it to always-ready.
    assign w_mem_rdy = i_mem_rdy | 1'b1;
`endif

    // Strobes are only released while running and not in reset.
    assign w_run = i_ena & ~i_rst;

    // State register and DECODE-time capture of the zero flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_FETCH_HI;
            r_zero_q <= 1'b0;
        end else if (i_ena) begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_zero_q <= i_zero;
            end
        end
    end

    // Next-state and raw strobe decode from the registered state.
    always_comb begin
        w_next        = r_state;
        w_pc_inc      = 1'b0;
        w_pc_load     = 1'b0;
        w_addr_sel    = 1'b0;
        w_load_ir_hi  = 1'b0;
        w_load_ir_lo  = 1'b0;
        w_load_acc    = 1'b0;
        w_rd          = 1'b0;
        w_wr          = 1'b0;
        w_datactl_ena = 1'b0;
        w_halt        = 1'b0;
        case (r_state)
            S_FETCH_HI: begin
                w_rd         = 1'b1;
                w_load_ir_hi = 1'b1;
                w_pc_inc     = w_mem_rdy;
                if (w_mem_rdy) begin
                    w_next = S_FETCH_LO;
                end else begin
                    w_next = S_FETCH_HI;
                end
            end
            S_FETCH_LO: begin
                w_rd         = 1'b1;
                w_load_ir_lo = 1'b1;
                w_pc_inc     = w_mem_rdy;
                if (w_mem_rdy) begin
                    w_next = S_DECODE;
                end else begin
                    w_next = S_FETCH_LO;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC1;
            end
            S_EXEC1: begin
                w_next = S_EXEC2;
                case (i_opcode)
                    OP_HLT: begin
                        w_halt = 1'b1;
                        w_next = S_HALTED;
                    end
                    OP_SKZ: w_pc_inc  = r_zero_q;
                    OP_JMP: w_pc_load = 1'b1;
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                        w_rd       = 1'b1;
                        w_addr_sel = 1'b1;
                    end
                    OP_STO: begin
                        w_datactl_ena = 1'b1;
                        w_addr_sel    = 1'b1;
                    end
                    default: w_next = S_EXEC2;
                endcase
            end
            S_EXEC2: begin
                w_next = S_FETCH_HI;
                case (i_opcode)
                    OP_SKZ: w_pc_inc = r_zero_q;
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                        w_rd       = 1'b1;
                        w_addr_sel = 1'b1;
                        w_load_acc = w_mem_rdy;
                        if (w_mem_rdy) begin
                            w_next = S_FETCH_HI;
                        end else begin
                            w_next = S_EXEC2;
                        end
                    end
                    OP_STO: begin
                        w_wr          = 1'b1;
                        w_datactl_ena = 1'b1;
                        w_addr_sel    = 1'b1;
                        if (w_mem_rdy) begin
                            w_next = S_FETCH_HI;
                        end else begin
                            w_next = S_EXEC2;
                        end
                    end
                    default: w_next = S_FETCH_HI;
                endcase
            end
            S_HALTED: begin
                w_halt = 1'b1;
                w_next = S_HALTED;
            end
            // Illegal encodings recover to a fresh fetch.
            default: w_next = S_FETCH_HI;
        endcase
    end

    assign o_pc_inc      = w_pc_inc      & w_run;
    assign o_pc_load     = w_pc_load     & w_run;
    assign o_addr_sel    = w_addr_sel    & w_run;
    assign o_load_ir_hi  = w_load_ir_hi  & w_run;
    assign o_load_ir_lo  = w_load_ir_lo  & w_run;
    assign o_load_acc    = w_load_acc    & w_run;
    assign o_rd          = w_rd          & w_run;
    assign o_wr          = w_wr          & w_run;
    assign o_datactl_ena = w_datactl_ena & w_run;
    assign o_halt        = w_halt        & w_run;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed bench for cpu_sequencer. Outputs are packed into one 10-bit vector
// {pc_inc, pc_load, addr_sel, load_ir_hi, load_ir_lo, load_acc, rd, wr,
//  datactl_ena, halt} and compared cycle by cycle against hand-written values.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_rdy;
    logic       pc_inc, pc_load, addr_sel, load_ir_hi, load_ir_lo;
    logic       load_acc, rd, wr, datactl_ena, halt;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected output vectors, bit order as in the header.
    localparam logic [9:0] V_IDLE   = 10'b0000000000;
    localparam logic [9:0] V_FH     = 10'b1001001000;
    localparam logic [9:0] V_FH_STL = 10'b0001001000;
    localparam logic [9:0] V_FL     = 10'b1000101000;
    localparam logic [9:0] V_E1_RD  = 10'b0010001000;
    localparam logic [9:0] V_E2_RD  = 10'b0010011000;
    localparam logic [9:0] V_PCINC  = 10'b1000000000;
    localparam logic [9:0] V_JMP1   = 10'b0100000000;
    localparam logic [9:0] V_STO1   = 10'b0010000010;
    localparam logic [9:0] V_STO2   = 10'b0010000110;
    localparam logic [9:0] V_HALT   = 10'b0000000001;

    logic [9:0] obs;
    assign obs = {pc_inc, pc_load, addr_sel, load_ir_hi, load_ir_lo,
                  load_acc, rd, wr, datactl_ena, halt};

    cpu_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ena         (ena),
        .i_opcode      (opcode),
        .i_zero        (zero),
        .i_mem_rdy     (mem_rdy),
        .o_pc_inc      (pc_inc),
        .o_pc_load     (pc_load),
        .o_addr_sel    (addr_sel),
        .o_load_ir_hi  (load_ir_hi),
        .o_load_ir_lo  (load_ir_lo),
        .o_load_acc    (load_acc),
        .o_rd          (rd),
        .o_wr          (wr),
        .o_datactl_ena (datactl_ena),
        .o_halt        (halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] exp);
        #1;
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check the current cycle, then advance to 1 time unit after the next edge.
    task automatic step(input string tag, input logic [9:0] exp);
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        ena     = 1'b1;
        mem_rdy = 1'b1;
        opcode  = 3'b010;
        zero    = 1'b0;

        // Reset held two cycles; outputs must stay quiet.
        @(posedge clk); #1;
        step("rst_c1", V_IDLE);
        step("rst_c2", V_IDLE);
        rst = 1'b0;

        // ADD, unstalled.
        step("add_fh",  V_FH);
        step("add_fl",  V_FL);
        step("add_dec", V_IDLE);
        step("add_e1",  V_E1_RD);
        step("add_e2",  V_E2_RD);

        // SKZ with zero set: two extra increments.
        opcode = 3'b001; zero = 1'b1;
        step("skz1_fh",  V_FH);
        step("skz1_fl",  V_FL);
        step("skz1_dec", V_IDLE);
        zero = 1'b0;  // only the DECODE sample counts
        step("skz1_e1",  V_PCINC);
        step("skz1_e2",  V_PCINC);

        // SKZ with zero clear: no extra increments.
        zero = 1'b0;
        step("skz0_fh",  V_FH);
        step("skz0_fl",  V_FL);
        zero = 1'b0;
        step("skz0_dec", V_IDLE);
        zero = 1'b1;  // changes after DECODE are ignored
        step("skz0_e1",  V_IDLE);
        step("skz0_e2",  V_IDLE);
        zero = 1'b0;

        // JMP.
        opcode = 3'b111;
        step("jmp_fh",  V_FH);
        step("jmp_fl",  V_FL);
        step("jmp_dec", V_IDLE);
        step("jmp_e1",  V_JMP1);
        step("jmp_e2",  V_IDLE);

        // STO.
        opcode = 3'b110;
        step("sto_fh",  V_FH);
        step("sto_fl",  V_FL);
        step("sto_dec", V_IDLE);
        step("sto_e1",  V_STO1);
        step("sto_e2",  V_STO2);

        // Memory stall in FETCH_HI.
        opcode = 3'b010;
        mem_rdy = 1'b0;
`ifdef CPU_SEQ_MEMWAIT_EN
        step("stall_c1", V_FH_STL);
        step("stall_c2", V_FH_STL);
        step("stall_c3", V_FH_STL);
        mem_rdy = 1'b1;
        step("stall_c4", V_FH);
        step("stall_fl", V_FL);
        step("stall_dec", V_IDLE);
`else
        step("nostall_fh",  V_FH);
        step("nostall_fl",  V_FL);
        step("nostall_dec", V_IDLE);
        mem_rdy = 1'b1;
`endif
        step("stall_e1", V_E1_RD);
        step("stall_e2", V_E2_RD);

        // ena dropped in EXEC1 for 4 cycles, then resume in EXEC1.
        step("ena_fh",  V_FH);
        step("ena_fl",  V_FL);
        step("ena_dec", V_IDLE);
        ena = 1'b0;
        step("ena_off1", V_IDLE);
        step("ena_off2", V_IDLE);
        step("ena_off3", V_IDLE);
        step("ena_off4", V_IDLE);
        ena = 1'b1;
        step("ena_e1", V_E1_RD);
        step("ena_e2", V_E2_RD);

        // Reset during STO EXEC2 (stalled when wait is enabled).
        opcode = 3'b110;
        step("rsto_fh",  V_FH);
        step("rsto_fl",  V_FL);
        step("rsto_dec", V_IDLE);
        step("rsto_e1",  V_STO1);
        mem_rdy = 1'b0;
`ifdef CPU_SEQ_MEMWAIT_EN
        step("rsto_stall", V_STO2);
`endif
        rst = 1'b1;
        step("rsto_rst", V_IDLE);
        rst = 1'b0;
        mem_rdy = 1'b1;
        opcode = 3'b010;
        step("rsto_fh2", V_FH);
        step("rsto_fl2", V_FL);

        // Finish that ADD, then HLT.
        step("rsto_dec2", V_IDLE);
        step("rsto_e1b",  V_E1_RD);
        step("rsto_e2b",  V_E2_RD);
        opcode = 3'b000;
        step("hlt_fh",  V_FH);
        step("hlt_fl",  V_FL);
        step("hlt_dec", V_IDLE);
        step("hlt_e1",  V_HALT);
        opcode = 3'b010;  // halted state ignores opcode
        for (int i = 0; i < 20; i++) begin
            step("hlt_hold", V_HALT);
        end
        rst = 1'b1;
        step("hlt_rst", V_IDLE);
        rst = 1'b0;
        step("hlt_recover", V_FH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction-cycle controller for the toy processor. Drives the 13-bit program counter's increment and load strobes, the instruction-register byte loads, accumulator load, memory read/write and data-bus enable, and halts on HLT. It sits between the instruction register/accumulator datapath and memory, and sequences one 16-bit instruction (3-bit opcode, 13-bit address) through a fixed multi-state cycle, stalling on memory wait.

## Interface

- No parameters. Opcode width is 3 and state encoding is internal.
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- ena  in  1  run enable. Low: state frozen, all strobes 0.
- opcode  in  3  ir[15:13]; valid from DECODE onward.
- zero  in  1  accumulator-is-zero flag.
- mem_rdy  in  1  memory completes the current rd/wr this cycle.
- pc_inc  out  1  PC increment enable.
- pc_load  out  1  PC loads ir[12:0].
- addr_sel  out  1  memory address source: 0 = PC, 1 = ir[12:0].
- load_ir_hi  out  1  IR high byte captures memory data.
- load_ir_lo  out  1  IR low byte captures memory data.
- load_acc  out  1  accumulator captures ALU result.
- rd  out  1  memory read.
- wr  out  1  memory write.
- datactl_ena  out  1  drive accumulator onto the data bus.
- halt  out  1  processor halted.

## Operation

- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- States: FETCH_HI, FETCH_LO, DECODE, EXEC1, EXEC2, HALTED. Outputs are decoded combinationally from the registered state, opcode, the registered zero flag and mem_rdy.
- FETCH_HI: rd=1, addr_sel=0, load_ir_hi=1. When mem_rdy is high, pc_inc=1 and the FSM goes to FETCH_LO.
- FETCH_LO: same as FETCH_HI, but with load_ir_lo=1. When mem_rdy is high, pc_inc=1 and the FSM goes to DECODE.
- DECODE: all strobes 0. Captures zero into zero_q. Goes to EXEC1.
- EXEC1, by opcode:
  - HLT: halt=1, go to HALTED.
  - SKZ: pc_inc=zero_q.
  - JMP: pc_load=1.
  - ADD/AND/XOR/LDA: rd=1, addr_sel=1.
  - STO: datactl_ena=1, addr_sel=1.
  - Always goes to EXEC2.
- EXEC2, by opcode:
  - SKZ: pc_inc=zero_q. Together with EXEC1 this skips the PC by +2.
  - ADD/AND/XOR/LDA: rd=1, addr_sel=1, load_acc=mem_rdy.
  - STO: wr=1, datactl_ena=1, addr_sel=1.
  - JMP: all strobes 0.
  - Any state waiting on memory leaves only when mem_rdy is high, then goes to FETCH_HI.
- HALTED: halt=1, all other strobes 0. Exits only via rst.
- Invariants:
  - pc_inc and pc_load are never both 1.
  - rd and wr are never both 1.
  - wr=1 implies datactl_ena=1.

## Timing

- Reset: state=FETCH_HI, zero_q=0, all outputs 0.
  - The first fetch rd appears in the cycle after rst deasserts, provided ena=1.
- Reset mid-instruction (any state, including a memory stall) aborts the instruction. No further strobes are issued.
- Unstalled latency per instruction: 5 cycles. HLT takes 4 cycles to reach HALTED.
- Memory stall: the FSM stays in the state, and rd/wr/addr_sel/datactl_ena hold steady. pc_inc and load_acc stay 0 until the mem_rdy cycle.
- ena low:
  - State and zero_q are held and all outputs are forced to 0.
  - On resume the FSM continues from the held state.
  - rst overrides ena.
- opcode must be stable from DECODE through EXEC2. zero is sampled only in DECODE.

## Configuration

- CPU_SEQ_MEMWAIT_EN defined: mem_rdy is honoured as described above.
- CPU_SEQ_MEMWAIT_EN undefined: mem_rdy is ignored and internally treated as 1, so every state takes exactly one cycle. The port remains present.

## Test plan

- Reset and fetch: rst for 2 cycles, then mem_rdy=1 and opcode=010 (ADD).
  - Expected state sequence: FETCH_HI → FETCH_LO → DECODE → EXEC1 → EXEC2, 5 cycles.
  - pc_inc=1 in cycles 1 and 2; load_acc=1 in cycle 5.
  - All outputs 0 during reset.
- SKZ:
  - With zero=1 at DECODE: pc_inc=1 in both EXEC1 and EXEC2 (PC +4 over the instruction).
  - With zero=0: only the 2 fetch increments.
- JMP and STO:
  - JMP: pc_load=1 only in EXEC1, and pc_inc=0 there.
  - STO: EXEC1 gives datactl_ena=1 and wr=0; EXEC2 gives wr=1, datactl_ena=1 and addr_sel=1.
- Memory stall (macro defined): hold mem_rdy=0 for 3 cycles in FETCH_HI.
  - rd=1 held and pc_inc=0 for those 3 cycles.
  - pc_inc=1 exactly in the 4th cycle.
  - With the macro undefined, the same stimulus advances every cycle.
- HLT and reset recovery: opcode=000 gives halt=1 from EXEC1 onward and stays 1 for 20 cycles. A rst pulse returns the FSM to FETCH_HI with halt=0.
- ena and reset mid-operation:
  - Drop ena in EXEC1 for 4 cycles: outputs are 0, and the FSM resumes in EXEC1.
  - Assert rst during an EXEC2 stall: the next state is FETCH_HI and no wr is issued.
